// File: rtl/pfd_sampled.sv
// Sampled phase-frequency detector: clk_ref/clk_fb are oversampled on clk_in and compared edge-to-edge.
// Optional lock detector enabled by defining PFD_LOCK_DETECT_EN; otherwise lock is tied low.
module pfd_sampled #(
  parameter int ERR_W    = 8,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    clk_ref,
  input  logic                    clk_fb,
  output logic                    up,
  output logic                    dn,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    phase_err_vld,
  output logic                    lock
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DN   = 2'b10
  } state_t;

  localparam logic [ERR_W-1:0] WIDTH_MAX = {1'b0, {(ERR_W-1){1'b1}}};

  if (LOCK_CNT < 1 || LOCK_TOL < 0) begin : g_bad_cfg
    $error("pfd_sampled: LOCK_CNT must be >= 1 and LOCK_TOL >= 0");
  end

  logic [1:0] ref_sync, fb_sync;
  logic       ref_dly, fb_dly;
  logic       ref_e, fb_e;

  state_t                    state, state_nxt;
  logic [ERR_W-1:0]          width;
  logic                      emit;
  logic signed [ERR_W-1:0]   emit_val;

  // Two-flop synchronisers followed by a registered rising-edge detect.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_dly  <= 1'b0;
      fb_dly   <= 1'b0;
      ref_e    <= 1'b0;
      fb_e     <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[0], clk_ref};
      fb_sync  <= {fb_sync[0], clk_fb};
      ref_dly  <= ref_sync[1];
      fb_dly   <= fb_sync[1];
      ref_e    <= ref_sync[1] & ~ref_dly;
      fb_e     <= fb_sync[1] & ~fb_dly;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_val  = '0;
    case (state)
      IDLE: begin
        if (ref_e && fb_e) begin
          emit = 1'b1;
        end else if (ref_e) begin
          state_nxt = UP;
        end else if (fb_e) begin
          state_nxt = DN;
        end
      end
      UP: begin
        if (fb_e) begin
          state_nxt = IDLE;
          emit      = 1'b1;
          emit_val  = $signed(width);
        end
      end
      DN: begin
        if (ref_e) begin
          state_nxt = IDLE;
          emit      = 1'b1;
          emit_val  = -$signed(width);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      width         <= '0;
      phase_err     <= '0;
      phase_err_vld <= 1'b0;
    end else begin
      state         <= state_nxt;
      phase_err_vld <= emit;
      if (emit) phase_err <= emit_val;
      // Leaving IDLE already counts the first cycle spent in UP/DN.
      if (state == IDLE) begin
        if (state_nxt != IDLE) width <= {{(ERR_W-1){1'b0}}, 1'b1};
      end else if (width != WIDTH_MAX) begin
        width <= width + 1'b1;
      end
    end
  end

  assign up = (state == UP);
  assign dn = (state == DN);

`ifdef PFD_LOCK_DETECT_EN
  localparam int               LCW     = $clog2(LOCK_CNT + 1);
  localparam logic [LCW-1:0]   CNT_MAX = LCW'(LOCK_CNT);
  localparam logic [ERR_W-1:0] TOL     = ERR_W'(LOCK_TOL);

  logic [LCW-1:0]   lock_cnt;
  logic [ERR_W-1:0] err_mag;
  logic             in_tol;

  assign err_mag = emit_val[ERR_W-1] ? ERR_W'(-emit_val) : ERR_W'(emit_val);
  assign in_tol  = (err_mag <= TOL);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (emit) begin
      if (!in_tol)                    lock_cnt <= '0;
      else if (lock_cnt != CNT_MAX)   lock_cnt <= lock_cnt + 1'b1;
    end
  end

  assign lock = (lock_cnt == CNT_MAX);
`else
  assign lock = 1'b0;
`endif

endmodule
